// File: rtl/sig_frame_deser.sv
// Bit-stream frame deserializer: hunts a sync pattern, shifts in a DATA_W payload MSB first,
// checks one parity bit and reports a frame, parity error or inter-bit timeout.
module sig_frame_deser #(
  parameter int                DATA_W    = 8,
  parameter int                SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT  = 4'b1011,
  parameter bit                PAR_ODD   = 1'b1,
  parameter int                TMO_W     = 10,
  parameter int                TMO_TH    = 16,
  parameter int                ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_bit_vld,
  input  logic                 i_bit_data,
  output logic                 o_frm_vld,
  output logic [DATA_W-1:0]    o_frm_data,
  output logic                 o_par_err,
  output logic                 o_tmo_err,
  output logic                 o_busy,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {HUNT, DATA, PAR} state_e;

  state_e            state, state_nxt;
  logic [SYNC_W-1:0] sync_sr, sync_shift;
  logic [DATA_W-1:0] data_sr, data_shift;
  logic [CNT_W-1:0]  bit_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              sync_hit, tmo_hit, par_ok, frm_done, err_evt;

  // Truncating casts keep the shift well-formed even for DATA_W == 1.
  assign sync_shift = SYNC_W'({sync_sr, i_bit_data});
  assign data_shift = DATA_W'({data_sr, i_bit_data});
  assign sync_hit   = i_bit_vld && (sync_shift == SYNC_PAT);
  // An arriving bit always beats the timeout on the same cycle.
  assign tmo_hit    = (state != HUNT) && !i_bit_vld && (tmo_cnt == TMO_W'(TMO_TH - 1));
  assign par_ok     = ((^{data_sr, i_bit_data}) == PAR_ODD);
  assign err_evt    = (frm_done && !par_ok) || tmo_hit;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= HUNT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    frm_done  = 1'b0;
    case (state)
      HUNT: if (sync_hit) state_nxt = DATA;
      DATA: begin
        if (i_bit_vld && (bit_cnt == CNT_W'(DATA_W - 1))) state_nxt = PAR;
        else if (tmo_hit)                                 state_nxt = HUNT;
      end
      PAR: begin
        if (i_bit_vld) begin
          state_nxt = HUNT;
          frm_done  = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_sr    <= '0;
      data_sr    <= '0;
      bit_cnt    <= '0;
      tmo_cnt    <= '0;
      o_frm_vld  <= 1'b0;
      o_frm_data <= '0;
      o_par_err  <= 1'b0;
      o_tmo_err  <= 1'b0;
      o_busy     <= 1'b0;
      o_err_cnt  <= '0;
    end else begin
      o_frm_vld <= 1'b0;
      o_par_err <= 1'b0;
      o_tmo_err <= tmo_hit;
      o_busy    <= (state_nxt != HUNT);

      if (state == HUNT) begin
        tmo_cnt <= '0;
        if (i_bit_vld) sync_sr <= sync_hit ? '0 : sync_shift;
        if (sync_hit) begin
          bit_cnt <= '0;
          data_sr <= '0;
        end
      end else begin
        if (i_bit_vld || tmo_hit) tmo_cnt <= '0;
        else                      tmo_cnt <= tmo_cnt + 1'b1;
        if ((state == DATA) && i_bit_vld) begin
          data_sr <= data_shift;
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (frm_done) begin
          o_frm_data <= data_sr;
          o_frm_vld  <= par_ok;
          o_par_err  <= !par_ok;
        end
      end

      if (err_evt && (o_err_cnt != '1)) o_err_cnt <= o_err_cnt + 1'b1;
    end
  end

`ifdef ASSERT_ON
  always @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (SYNC_W >= 2) else $error("SYNC_W must be >= 2");
      assert (TMO_TH >= 1) else $error("TMO_TH must be >= 1");
      assert ($onehot0({o_frm_vld, o_par_err, o_tmo_err})) else $error("result pulses overlap");
    end
  end
`endif

endmodule

// File: doc/sig_frame_deser.md
Name: sig_frame_deser

Overview:
- Consumes the decoded bit stream produced by the pulse-run detector stage (one valid strobe plus one data bit per detected symbol).
- Hunts for a sync pattern, then assembles a fixed-width data word MSB first, then checks one parity bit.
- Outputs a registered frame pulse with data, or an error pulse.
- Sits between the bit-level detector and the register/command decode logic.

Parameters:
- DATA_W, 8: payload bits per frame (>=1).
- SYNC_W, 4: sync pattern length (>=2).
- SYNC_PAT, 4'b1011: sync pattern; first-received bit is the MSB.
- PAR_ODD, 1: 1 = odd parity over data+parity bit; 0 = even.
- TMO_W, 10: width of the inter-bit timeout counter.
- TMO_TH, 16: idle cycles between bits that abort a frame (1..2^TMO_W-1).
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_bit_vld  in  1  bit strobe from upstream detector; may be back-to-back
- i_bit_data  in  1  bit value, qualified by i_bit_vld
- o_frm_vld  out  1  one-cycle pulse: good frame
- o_frm_data  out  DATA_W  last assembled payload; held between frames
- o_par_err  out  1  one-cycle pulse: parity mismatch
- o_tmo_err  out  1  one-cycle pulse: inter-bit timeout
- o_busy  out  1  high when state != HUNT
- o_err_cnt  out  ERR_CNT_W  saturating count of par+tmo errors

Behaviour:
- Reset: one clock, synchronous, active-low (i_rst_n sampled on i_clk rising edge). State = HUNT; all shift registers, counters and outputs = 0. Reset mid-frame discards the partial frame; no error is flagged.
- FSM states: HUNT, DATA, PAR. The state advances only on cycles where i_bit_vld=1, except on timeout.
- HUNT:
  - On each i_bit_vld: sync_sr <= {sync_sr[SYNC_W-2:0], i_bit_data}.
  - If the shifted value == SYNC_PAT, go to DATA and clear sync_sr, bit_cnt, data_sr and tmo_cnt.
  - Overlapping matches are allowed (e.g. prefix 1,1,0,1,1 matches on the 5th bit).
- DATA:
  - On i_bit_vld: data_sr <= {data_sr[DATA_W-2:0], i_bit_data}; bit_cnt++.
  - When the bit with bit_cnt == DATA_W-1 is accepted, go to PAR.
- PAR, on i_bit_vld:
  - ok = ^{data_sr, i_bit_data} == PAR_ODD.
  - Next cycle: o_frm_data <= data_sr (always updated); o_frm_vld <= ok; o_par_err <= ~ok.
  - Go to HUNT.
- Latency: frame result is visible 1 cycle after the parity-bit strobe.
- Timeout (DATA/PAR only):
  - tmo_cnt clears on i_bit_vld and increments on cycles without it.
  - On a cycle with i_bit_vld=0 and tmo_cnt == TMO_TH-1: go to HUNT, o_tmo_err <= 1 next cycle, tmo_cnt <= 0, partial data dropped.
  - A bit arriving on that same cycle wins: it is accepted and no timeout occurs.
  - tmo_cnt is held at 0 in HUNT.
- Error counter: o_err_cnt increments by 1 on each o_par_err or o_tmo_err event and saturates at all-ones. Par and tmo errors cannot coincide. Cleared only by reset.
- Output timing: o_frm_vld, o_par_err and o_tmo_err are registered, one cycle wide, and mutually exclusive. o_busy is registered and follows state.
- Width rules: bit_cnt width = $clog2(DATA_W)+1; tmo_cnt is TMO_W bits and never wraps.
- Assertions, under ASSERT_ON: SYNC_W >= 2, TMO_TH >= 1, no two error/valid pulses high together.

Test Plan (DATA_W=8, SYNC_PAT=4'b1011, PAR_ODD=1, TMO_TH=16 unless noted):
1. Bits 1,0,1,1 then 1,0,1,0,0,1,0,1 (0xA5), parity 1, all back-to-back -> o_frm_vld=1 for exactly 1 cycle, 1 cycle after the parity strobe; o_frm_data=0xA5; o_par_err=0; o_err_cnt=0.
2. Same frame with parity 0 -> o_par_err pulse; o_frm_vld=0; o_frm_data=0xA5; o_err_cnt=1.
3. Prefix 0,1,1,0,1,1 then 0x3C with parity 1 -> sync found on the 6th bit; o_frm_data=0x3C; o_frm_vld pulse.
4. Sync + 3 data bits, then 16 idle cycles -> o_tmo_err pulse on the cycle after the 16th idle cycle; o_busy=0. Same setup with a bit on the 16th idle cycle -> no timeout, frame continues. A following good frame (0x5A, parity 1) decodes correctly.
5. i_rst_n=0 for 1 cycle after 5 data bits -> all outputs 0 next cycle; no error pulse. A following good frame decodes correctly.
6. ERR_CNT_W=2, five consecutive parity-error frames -> o_err_cnt = 1,2,3,3,3.
